// File: rtl/li_expander_if.sv
// Request/response bundle for the li pseudo-instruction expander.
// The producer/consumer side uses master; the expander uses slave.
interface li_expander_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [4:0]  in_rt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;

  modport master (
    output in_valid, in_value, in_rt, out_ready,
    input  in_ready, out_valid, out_instr, out_last
  );

  modport slave (
    input  in_valid, in_value, in_rt, out_ready,
    output in_ready, out_valid, out_instr, out_last
  );
endinterface

// File: rtl/li_expander.sv
// Expands "li rt, value" into LUI/ORI instruction words streamed over valid/ready.
// The output registers always hold the word of the current state, so outputs are registered.
module li_expander #(
  parameter int OPT_SHORT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  li_expander_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EMIT_LUI = 2'd1,
    EMIT_ORI = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lo_q, lo_d;
  logic [4:0]  rt_q, rt_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_last_q, out_last_d;
  logic        in_ready_q;
  logic        accept_s;
  logic [15:0] in_hi_s;
  logic [15:0] in_lo_s;

  function automatic logic [31:0] enc_lui(input logic [4:0] rt, input logic [15:0] hi);
    return {6'b001111, 5'd0, rt, hi};
  endfunction

  function automatic logic [31:0] enc_ori(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] lo);
    return {6'b001101, rs, rt, lo};
  endfunction

  assign in_hi_s  = bus.in_value[31:16];
  assign in_lo_s  = bus.in_value[15:0];
  assign accept_s = bus.in_valid && in_ready_q;

  // Next-state and next-output selection
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    rt_d        = rt_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          lo_d        = in_lo_s;
          rt_d        = bus.in_rt;
          out_valid_d = 1'b1;
          if ((OPT_SHORT != 0) && (in_hi_s == 16'h0000)) begin
            // Short ORI form uses $0 as source so the upper half is cleared
            state_d     = EMIT_ORI;
            out_instr_d = enc_ori(5'd0, bus.in_rt, in_lo_s);
            out_last_d  = 1'b1;
          end else begin
            state_d     = EMIT_LUI;
            out_instr_d = enc_lui(bus.in_rt, in_hi_s);
            out_last_d  = (OPT_SHORT != 0) && (in_lo_s == 16'h0000);
          end
        end else begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      EMIT_LUI: begin
        if (bus.out_ready) begin
          if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_instr_d = 32'h0000_0000;
            out_last_d  = 1'b0;
          end else begin
            state_d     = EMIT_ORI;
            out_instr_d = enc_ori(rt_q, rt_q, lo_q);
            out_last_d  = 1'b1;
          end
        end else begin
          state_d = EMIT_LUI;
        end
      end
      EMIT_ORI: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_instr_d = 32'h0000_0000;
          out_last_d  = 1'b0;
        end else begin
          state_d = EMIT_ORI;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_instr_d = 32'h0000_0000;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // State, captured operands and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lo_q        <= 16'h0000;
      rt_q        <= 5'd0;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0000_0000;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      rt_q        <= rt_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= (state_d == IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_last  = out_last_q;

endmodule
